// File: rtl/ray_box_list_tracer.sv
// Ray vs. axis-aligned box list tracer: walks every face of every enabled box,
// divides with one shared restoring divider and keeps the nearest accepted hit.
module ray_box_list_tracer #(
  parameter int unsigned CW   = 10,
  parameter int unsigned DW   = 11,
  parameter int unsigned TW   = 10,
  parameter int unsigned NBOX = 4,
  localparam int unsigned IDW = (NBOX > 1) ? $clog2(NBOX) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3*CW-1:0]        origin,
  input  logic [3*DW-1:0]        dir,
  input  logic [NBOX*6*CW-1:0]   boxes,
  input  logic [NBOX-1:0]        box_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   hit,
  output logic [TW-1:0]          t_out,
  output logic [IDW-1:0]         box_id,
  output logic [2:0]             face,
  output logic [3*DW-1:0]        normal
);

  localparam int unsigned VW   = CW + DW + TW + 1;
  localparam int unsigned QW   = (CW > TW) ? CW : TW;
  localparam int unsigned CNTW = $clog2(CW + 1);
  localparam logic [TW-1:0] TMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DIV, S_CHECK, S_NEXT, S_DONE} state_t;

  state_t                r_state;
  logic [3*CW-1:0]       r_org;
  logic [3*DW-1:0]       r_dir;
  logic [NBOX*6*CW-1:0]  r_boxes;
  logic [NBOX-1:0]       r_en;
  logic [2:0]            r_f;
  logic [IDW-1:0]        r_b;
  logic [DW-1:0]         r_rem;
  logic [CW-1:0]         r_quo;
  logic [DW-1:0]         r_dvs;
  logic [CNTW-1:0]       r_cnt;
  logic [TW-1:0]         r_best_t;
  logic [IDW-1:0]        r_best_b;
  logic [2:0]            r_best_f;
  logic                  r_best_hit;

  logic [6*CW-1:0]       w_box;
  logic [CW-1:0]         w_o  [3];
  logic signed [DW-1:0]  w_d  [3];
  logic [CW-1:0]         w_lo [3];
  logic [CW-1:0]         w_hi [3];
  logic [1:0]            w_a;
  logic [CW-1:0]         w_p;
  logic [CW-1:0]         w_oa;
  logic signed [DW-1:0]  w_da;
  logic signed [CW:0]    w_num;
  logic [CW-1:0]         w_num_abs;
  logic [DW-1:0]         w_d_abs;
  logic                  w_skip;
  logic [DW:0]           w_trial;
  logic [DW:0]           w_sub;
  logic                  w_ge;
  logic [QW-1:0]         w_q_ext;
  logic [TW-1:0]         w_q;
  logic signed [VW-1:0]  w_v [3];
  logic                  w_ok;

  // Outward unit normal of a face code: even faces point down the axis, odd up.
  function automatic logic [3*DW-1:0] face_normal(input logic [2:0] f);
    logic [3*DW-1:0] n;
    n = '0;
    n[(2 - int'(f[2:1]))*DW +: DW] = f[0] ? DW'(1) : {DW{1'b1}};
    return n;
  endfunction

  // Operand selection for the current box/face from the latched ray and list.
  always_comb begin
    w_box = r_boxes[int'(r_b)*6*CW +: 6*CW];
    for (int a = 0; a < 3; a++) begin
      w_o[a]  = r_org[(2-a)*CW +: CW];
      w_d[a]  = r_dir[(2-a)*DW +: DW];
      w_lo[a] = w_box[(5-2*a)*CW +: CW];
      w_hi[a] = w_box[(4-2*a)*CW +: CW];
    end
    w_a       = r_f[2:1];
    w_p       = r_f[0] ? w_hi[w_a] : w_lo[w_a];
    w_oa      = w_o[w_a];
    w_da      = w_d[w_a];
    w_num     = $signed({1'b0, w_p}) - $signed({1'b0, w_oa});
    w_num_abs = w_num[CW] ? CW'(-w_num) : w_num[CW-1:0];
    w_d_abs   = w_da[DW-1] ? DW'(-w_da) : DW'(w_da);
    w_skip    = !r_en[r_b] || (w_da == '0) ||
                ((w_num != '0) && (w_num[CW] != w_da[DW-1]));
  end

  // Restoring divider step and range check of the two other axes.
  always_comb begin
    w_trial = {r_rem, r_quo[CW-1]};
    w_ge    = (w_trial >= {1'b0, r_dvs});
    w_sub   = w_trial - {1'b0, r_dvs};
    w_q_ext = QW'(r_quo);
    w_q     = (w_q_ext > QW'(TMAX)) ? TMAX : TW'(w_q_ext);
    w_ok    = (w_q != TMAX);
    for (int c = 0; c < 3; c++) begin
      w_v[c] = $signed(VW'(w_o[c])) + VW'(w_d[c]) * $signed(VW'(w_q));
      if ((c != int'(w_a)) &&
          (($signed(VW'(w_lo[c])) > w_v[c]) || (w_v[c] > $signed(VW'(w_hi[c])))))
        w_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      hit        <= 1'b0;
      t_out      <= TMAX;
      box_id     <= '0;
      face       <= '0;
      normal     <= '0;
      r_org      <= '0;
      r_dir      <= '0;
      r_boxes    <= '0;
      r_en       <= '0;
      r_f        <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_best_t   <= TMAX;
      r_best_b   <= '0;
      r_best_f   <= '0;
      r_best_hit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready   <= 1'b0;
            r_org      <= origin;
            r_dir      <= dir;
            r_boxes    <= boxes;
            r_en       <= box_en;
            r_f        <= '0;
            r_b        <= '0;
            r_best_t   <= TMAX;
            r_best_b   <= '0;
            r_best_f   <= '0;
            r_best_hit <= 1'b0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_skip) begin
            r_state <= S_NEXT;
          end else begin
            r_rem   <= '0;
            r_quo   <= w_num_abs;
            r_dvs   <= w_d_abs;
            r_cnt   <= CNTW'(CW);
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? DW'(w_sub) : DW'(w_trial);
          r_quo <= {r_quo[CW-2:0], w_ge};
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) r_state <= S_CHECK;
        end
        S_CHECK: begin
          // Strict compare keeps the earliest box/face on equal t.
          if (w_ok && (w_q < r_best_t)) begin
            r_best_t   <= w_q;
            r_best_b   <= r_b;
            r_best_f   <= r_f;
            r_best_hit <= 1'b1;
          end
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          r_state <= S_SETUP;
          if (r_f != 3'd5) begin
            r_f <= r_f + 3'd1;
          end else begin
            r_f <= '0;
            if (r_b != IDW'(NBOX - 1)) begin
              r_b <= r_b + IDW'(1);
            end else begin
              out_valid <= 1'b1;
              hit       <= r_best_hit;
              t_out     <= r_best_t;
              box_id    <= r_best_b;
              face      <= r_best_f;
              normal    <= r_best_hit ? face_normal(r_best_f) : '0;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_box_list_tracer.sv
// Directed bench for ray_box_list_tracer: one-box and two-box instances,
// expected results queued at send time and checked when out_valid appears.
module tb_ray_box_list_tracer;

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 11;
  localparam int unsigned TW = 10;

  typedef struct {
    logic        hit;
    logic [9:0]  t;
    logic [0:0]  id;
    logic [2:0]  face;
    logic [32:0] norm;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic iv1 = 1'b0, iv2 = 1'b0;
  logic ir1, ir2;
  logic [29:0]  origin = '0;
  logic [32:0]  dir = '0;
  logic [119:0] boxes = '0;
  logic [1:0]   en = '0;
  logic         out_ready = 1'b1;
  logic o1_valid, o1_hit, o2_valid, o2_hit;
  logic [9:0]  o1_t, o2_t;
  logic [0:0]  o1_id, o2_id;
  logic [2:0]  o1_face, o2_face;
  logic [32:0] o1_norm, o2_norm;

  logic obs_ready, obs_valid, obs_hit;
  logic [9:0]  obs_t;
  logic [0:0]  obs_id;
  logic [2:0]  obs_face;
  logic [32:0] obs_norm;

  int sel = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ray_box_list_tracer #(.CW(CW), .DW(DW), .TW(TW), .NBOX(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .origin(origin), .dir(dir), .boxes(boxes[59:0]), .box_en(en[0:0]),
    .out_valid(o1_valid), .out_ready(out_ready), .hit(o1_hit), .t_out(o1_t),
    .box_id(o1_id), .face(o1_face), .normal(o1_norm)
  );

  ray_box_list_tracer #(.CW(CW), .DW(DW), .TW(TW), .NBOX(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
    .origin(origin), .dir(dir), .boxes(boxes), .box_en(en),
    .out_valid(o2_valid), .out_ready(out_ready), .hit(o2_hit), .t_out(o2_t),
    .box_id(o2_id), .face(o2_face), .normal(o2_norm)
  );

  always_comb begin
    if (sel == 0) begin
      obs_ready = ir1; obs_valid = o1_valid; obs_hit = o1_hit; obs_t = o1_t;
      obs_id = o1_id; obs_face = o1_face; obs_norm = o1_norm;
    end else begin
      obs_ready = ir2; obs_valid = o2_valid; obs_hit = o2_hit; obs_t = o2_t;
      obs_id = o2_id; obs_face = o2_face; obs_norm = o2_norm;
    end
  end

  function automatic logic [59:0] mkbox(input int xl, xh, yl, yh, zl, zh);
    return {10'(xl), 10'(xh), 10'(yl), 10'(yh), 10'(zl), 10'(zh)};
  endfunction

  function automatic logic [29:0] c3(input int x, y, z);
    return {10'(x), 10'(y), 10'(z)};
  endfunction

  function automatic logic [32:0] d3(input int x, y, z);
    return {11'(x), 11'(y), 11'(z)};
  endfunction

  function automatic exp_t mkexp(input logic h, input int t, input int id,
                                 input int f, input logic [32:0] n, input int lat);
    exp_t e;
    e.hit = h; e.t = 10'(t); e.id = 1'(id); e.face = 3'(f); e.norm = n; e.lat = lat;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input int s, input logic [29:0] o, input logic [32:0] d,
                      input logic [119:0] bx, input logic [1:0] e, input exp_t ex);
    int w;
    w = 0;
    sel = s;
    #0;
    while (!obs_ready && w < 200) begin @(posedge clk); #1; w++; end
    chk("in_ready_wait", 64'(obs_ready), 64'(1));
    origin = o; dir = d; boxes = bx; en = e;
    if (s == 0) iv1 = 1'b1; else iv2 = 1'b1;
    sb.push_back(ex);
    @(posedge clk); #1;
    iv1 = 1'b0; iv2 = 1'b0;
  endtask

  task automatic collect(input string tag);
    int cnt;
    exp_t e;
    cnt = 0;
    while (!obs_valid && cnt < 400) begin @(posedge clk); #1; cnt++; end
    chk({tag, "_valid"}, 64'(obs_valid), 64'(1));
    chk({tag, "_sb"}, 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.lat >= 0) chk({tag, "_lat"}, 64'(cnt), 64'(e.lat));
      chk({tag, "_hit"},  64'(obs_hit),  64'(e.hit));
      chk({tag, "_t"},    64'(obs_t),    64'(e.t));
      chk({tag, "_id"},   64'(obs_id),   64'(e.id));
      chk({tag, "_face"}, 64'(obs_face), 64'(e.face));
      chk({tag, "_norm"}, 64'(obs_norm), 64'(e.norm));
    end
  endtask

  logic [59:0] b_near, b_far;

  initial begin
    b_near = mkbox(10, 20, 0, 10, 0, 10);
    b_far  = mkbox(30, 40, 0, 10, 0, 10);

    // Reset values while rst is held low.
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", 64'(o1_valid), 64'(0));
    chk("rst_hit",   64'(o1_hit),   64'(0));
    chk("rst_t",     64'(o1_t),     64'(1023));
    chk("rst_norm",  64'(o1_norm),  64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready1", 64'(ir1), 64'(1));
    chk("rst_ready2", 64'(ir2), 64'(1));

    // Single-box cases.
    send(0, c3(0, 5, 5), d3(1, 0, 0), {60'(0), b_near}, 2'b01,
         mkexp(1'b1, 10, 0, 0, d3(-1, 0, 0), 34));
    collect("basic");
    send(0, c3(0, 5, 5), d3(0, 1, 0), {60'(0), b_near}, 2'b01,
         mkexp(1'b0, 1023, 0, 0, 33'(0), 23));
    collect("miss");
    send(0, c3(50, 5, 5), d3(-2, 0, 0), {60'(0), b_near}, 2'b01,
         mkexp(1'b1, 15, 0, 1, d3(1, 0, 0), 34));
    collect("negdir");

    // Two-box list: nearest, tie, disabled box.
    send(1, c3(0, 5, 5), d3(1, 0, 0), {b_near, b_far}, 2'b11,
         mkexp(1'b1, 10, 1, 0, d3(-1, 0, 0), 68));
    collect("nearest");
    send(1, c3(0, 5, 5), d3(1, 0, 0), {b_near, b_near}, 2'b11,
         mkexp(1'b1, 10, 0, 0, d3(-1, 0, 0), 68));
    collect("tie");
    send(1, c3(0, 5, 5), d3(1, 0, 0), {b_near, b_far}, 2'b01,
         mkexp(1'b1, 30, 0, 0, d3(-1, 0, 0), 46));
    collect("boxen");

    // Backpressure, with the origin disturbed after the accept.
    out_ready = 1'b0;
    send(0, c3(0, 5, 5), d3(1, 0, 0), {60'(0), b_near}, 2'b01,
         mkexp(1'b1, 10, 0, 0, d3(-1, 0, 0), 34));
    origin = c3(100, 100, 100);
    collect("bp");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(o1_valid), 64'(1));
      chk("bp_hold_t",     64'(o1_t),     64'(10));
      chk("bp_hold_ready", 64'(ir1),      64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 64'(ir1),      64'(1));
    chk("bp_release_valid", 64'(o1_valid), 64'(0));

    // Asynchronous reset in the middle of a division.
    send(0, c3(0, 5, 5), d3(1, 0, 0), {60'(0), b_near}, 2'b01,
         mkexp(1'b1, 10, 0, 0, d3(-1, 0, 0), 34));
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(o1_valid), 64'(0));
    chk("arst_t",     64'(o1_t),     64'(1023));
    chk("arst_hit",   64'(o1_hit),   64'(0));
    if (sb.size() > 0) void'(sb.pop_front());
    #2 rst = 1'b1;
    @(posedge clk); #1;
    send(0, c3(0, 5, 5), d3(1, 0, 0), {60'(0), b_near}, 2'b01,
         mkexp(1'b1, 10, 0, 0, d3(-1, 0, 0), 34));
    collect("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ray_box_list_tracer.md
Name: ray_box_list_tracer

Overview:
- Sequential ray / axis-aligned-box intersection engine. Tests one ray against a list of NBOX boxes, face by face.
- Reports the nearest hit: parametric t, box index, face code and outward unit normal.
- Generalised successor of the single-box tracer: parametrised widths and box count, valid/ready handshakes, and one shared serial divider instead of six parallel dividers.
- Sits between the ray generator and the shading stage. Distance scaling by |dir| is done downstream.

Parameters:
- CW, 10, coordinate width. Origin and box bounds are unsigned CW bits on all three axes.
- DW, 11, direction component width, signed two's complement.
- TW, 10, t width. The value 2^TW-1 is the miss sentinel.
- NBOX, 4, number of boxes in the list.
- IDW, $clog2(NBOX) (min 1), box index width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- in_valid, in, 1, ray and box list offered.
- in_ready, out, 1, block can accept a ray.
- origin, in, 3*CW, {x,y,z}.
- dir, in, 3*DW, {x,y,z} signed.
- boxes, in, NBOX*6*CW. Box i occupies bits [(i+1)*6*CW-1 -: 6*CW] as {x_lo,x_hi,y_lo,y_hi,z_lo,z_hi}.
- box_en, in, NBOX, per-box enable. A disabled box is never a candidate.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts result.
- hit, out, 1, at least one face accepted.
- t_out, out, TW, nearest t. All ones on a miss.
- box_id, out, IDW, box of the nearest hit.
- face, out, 3, 0..5 = -x,+x,-y,+y,-z,+z.
- normal, out, 3*DW, signed {nx,ny,nz}. Each component is -1, 0 or +1 per face; all zero on a miss.

Behaviour:
- Reset (rst low, asynchronous):
  - State forced to IDLE.
  - out_valid=0, hit=0, t_out=all ones, box_id=0, face=0, normal=0.
  - Any partial result is discarded.
  - in_ready=1 from the first clock edge after rst is released.
- Handshake:
  - in_ready = (state==IDLE).
  - Accept on in_valid & in_ready. origin, dir, boxes and box_en are latched at that edge; later changes on these inputs are ignored.
  - out_valid stays high with all result outputs stable until out_valid & out_ready. State returns to IDLE at that edge, so in_ready=1 the next cycle.
  - No new ray is accepted while the result is pending.
- FSM states: IDLE, SETUP, DIV, CHECK, NEXT, DONE.
  - The face counter f (0..5) and box counter b are cleared on accept.
  - Faces are visited in order box 0 face 0 … box NBOX-1 face 5.
- Per-face processing:
  - Plane p = lo (even f) or hi (odd f) of axis a = f/2.
  - SETUP (1 cycle): compute num = p - o_a as signed CW+1 bits.
  - Skip the face (SETUP→NEXT) if any of the following holds:
    - box_en[b]=0;
    - d_a==0;
    - num≠0 and sign(num)≠sign(d_a).
  - Otherwise go to DIV.
  - DIV: restoring divider computes |num| / |d_a|, one quotient bit per cycle, exactly CW cycles, truncating. The quotient saturates to 2^TW-1 if it exceeds it.
  - CHECK (1 cycle):
    - Reject if q == 2^TW-1.
    - Otherwise, for each of the two other axes c, evaluate o_c + d_c*q in signed CW+DW+TW+1 bits.
    - Accept if lo_c ≤ value ≤ hi_c (inclusive) on both axes.
    - An accepted face replaces the best result only if q < best_t (strict). Ties keep the earlier box/face.
  - NEXT (1 cycle): advance f, then b. After box NBOX-1 face 5, go to DONE.
- Latency: an evaluated face costs CW+3 cycles; a skipped face costs 2. out_valid rises at the edge ending the last NEXT. Example: CW=10 with 2 evaluated and 4 skipped faces gives 34 cycles after the accept edge.
- An origin inside a box reports the exit face; there is no special case.
- DONE: hit=1 if any face was accepted; t_out/box_id/face/normal hold the best result. On a miss, outputs take their reset values.

Test Plan (NBOX=1 box x[10,20] y[0,10] z[0,10], CW=10, TW=10 unless stated):
- Basic hit: origin (0,5,5), dir (+1,0,0) -> hit=1, t_out=10, face=0, normal (-1,0,0), box_id=0; out_valid exactly 34 cycles after accept.
- Miss: origin (0,5,5), dir (0,+1,0).
  - -y face skipped on sign; +y gives t=5 but x=0 is out of range.
  - -> hit=0, t_out=1023, normal 0, out_valid 23 cycles after accept.
- Negative direction: origin (50,5,5), dir (-2,0,0) -> +x gives t=15, -x gives t=20 -> t_out=15, face=1, normal (+1,0,0).
- Nearest of list and tie (NBOX=2):
  - box0 x[30,40], box1 x[10,20] (same yz), ray as the basic hit -> box_id=1, t_out=10.
  - Both boxes identical -> box_id=0.
  - box_en=2'b01 with box0 x[30,40] -> t_out=30, box_id=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0.
  - Pulse out_ready -> in_ready=1 the next cycle.
  - Changing origin mid-computation does not alter the result.
- Reset mid-DIV: drop rst -> out_valid=0 and t_out=1023 immediately (no clock edge). After release, a new basic-hit ray returns t_out=10 with normal latency.
